// File: rtl/elementwise_writeback_if.sv
// Bus bundle for elementwise_writeback: the row stream from the elementwise array
// and the write port into the activation SRAM. "slave" is the writeback block's view.
interface elementwise_writeback_if #(
  parameter int num = 4,
  parameter int AW  = 16
);
  logic                in_valid;
  logic                in_ready;
  logic [num*32-1:0]   in_data;
  logic                mem_we;
  logic [AW-1:0]       mem_addr;
  logic [num*8-1:0]    mem_wdata;
  logic                mem_ready;

  modport master (
    output in_valid, in_data, mem_ready,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  in_valid, in_data, mem_ready,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/elementwise_writeback.sv
// Requantizes rows of signed 32-bit lanes to packed int8, buffers them in a small FIFO
// and writes them to consecutive SRAM addresses, pulsing o_done after the programmed row count.
module elementwise_writeback #(
  parameter int num   = 4,
  parameter int DEPTH = 4,
  parameter int AW    = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_start,
  input  logic [AW-1:0]       i_base_addr,
  input  logic [15:0]         i_row_count,
  input  logic [4:0]          i_shift,
  output logic                o_busy,
  output logic                o_done,
  elementwise_writeback_if.slave bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]         r_state;
  logic [4:0]         r_shift;
  logic [15:0]        r_row_count;
  logic [15:0]        r_accepted;
  logic [15:0]        r_written;
  logic [AW-1:0]      r_addr;

  logic               r_s1_valid;
  logic [num*8-1:0]   r_s1_data;

  logic [num*8-1:0]   r_fifo_mem [DEPTH];
  logic [PW-1:0]      r_wr_ptr;
  logic [PW-1:0]      r_rd_ptr;
  logic [CW-1:0]      r_fifo_count;
  logic [num*8-1:0]   r_wdata_hold;

  logic               w_run;
  logic               w_accept;
  logic               w_push;
  logic               w_pop;
  logic               w_fifo_empty;
  logic               w_last_write;
  logic [num*8-1:0]   w_head;
  logic [num*8-1:0]   w_requant;

  // Round half toward +inf, then saturate; 33 bits keep x plus the rounding bias exact.
  function automatic logic [7:0] requant(input logic [31:0] x, input logic [4:0] sh);
    logic signed [32:0] rnd;
    logic signed [32:0] t;
    logic signed [32:0] r;
    rnd = (sh == 5'd0) ? 33'sd0 : (33'sd1 <<< (sh - 5'd1));
    t   = $signed({x[31], x}) + rnd;
    r   = t >>> sh;
    if (r > 33'sd127)       return 8'h7F;
    else if (r < -33'sd128) return 8'h80;
    else                    return r[7:0];
  endfunction

  assign w_run        = (r_state == S_RUN);
  assign w_fifo_empty = (r_fifo_count == '0);
  assign w_head       = r_fifo_mem[r_rd_ptr];
  assign w_push       = r_s1_valid;
  assign w_pop        = bus.mem_we & bus.mem_ready;
  assign w_accept     = bus.in_valid & bus.in_ready;
  assign w_last_write = (r_written == (r_row_count - 16'd1));

  // The row sitting in the requant stage reserves a FIFO slot so nothing in flight is dropped.
  assign bus.in_ready = w_run && (r_accepted < r_row_count) &&
                        (({1'b0, r_fifo_count} + (CW+1)'(r_s1_valid)) < (CW+1)'(DEPTH));

  assign bus.mem_we    = w_run & ~w_fifo_empty;
  assign bus.mem_addr  = r_addr;
  assign bus.mem_wdata = bus.mem_we ? w_head : r_wdata_hold;

  assign o_busy = w_run;
  assign o_done = (r_state == S_DONE);

  always_comb begin
    // NOTE: default assignment first so every path writes the signal and no latch is inferred.
    w_requant = '0;
    for (int i = 0; i < num; i++) begin
      w_requant[i*8 +: 8] = requant(bus.in_data[i*32 +: 32], r_shift);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_shift     <= '0;
      r_row_count <= '0;
      r_accepted  <= '0;
      r_written   <= '0;
      r_addr      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            if (i_row_count == 16'd0) begin
              r_state <= S_DONE;
            end else begin
              r_state     <= S_RUN;
              r_addr      <= i_base_addr;
              r_shift     <= i_shift;
              r_row_count <= i_row_count;
              r_accepted  <= '0;
              r_written   <= '0;
            end
          end
        end
        S_RUN: begin
          if (w_accept) r_accepted <= r_accepted + 16'd1;
          if (w_pop) begin
            r_written <= r_written + 16'd1;
            r_addr    <= r_addr + 1'b1;
            if (w_last_write) r_state <= S_DONE;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s1_valid   <= 1'b0;
      r_s1_data    <= '0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_fifo_count <= '0;
      r_wdata_hold <= '0;
    end else begin
      r_s1_valid <= w_accept;
      if (w_accept) r_s1_data <= w_requant;
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) begin
        r_rd_ptr     <= r_rd_ptr + 1'b1;
        r_wdata_hold <= w_head;
      end
      case ({w_push, w_pop})
        2'b10:   r_fifo_count <= r_fifo_count + 1'b1;
        2'b01:   r_fifo_count <= r_fifo_count - 1'b1;
        default: r_fifo_count <= r_fifo_count;
      endcase
    end
  end

  // NOTE: storage array has no reset; pointers and the output mux keep stale entries invisible.
  always_ff @(posedge clk) begin
    if (w_push) r_fifo_mem[r_wr_ptr] <= r_s1_data;
  end

endmodule

// File: tb/tb_elementwise_writeback.sv
// Randomized bench for elementwise_writeback: each scenario task drives a job and compares
// the observed SRAM writes against an arithmetic requantization model.
module tb_elementwise_writeback;

  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] base_addr;
  logic [15:0] row_count;
  logic [4:0]  shift;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_errors = 0;

  elementwise_writeback_if #(.num(4), .AW(16)) bus ();

  elementwise_writeback #(.num(4), .DEPTH(4), .AW(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .i_start    (start),
    .i_base_addr(base_addr),
    .i_row_count(row_count),
    .i_shift    (shift),
    .o_busy     (busy),
    .o_done     (done),
    .bus        (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Job log filled by run_job and inspected by the scenario tasks.
  logic [127:0] stim_q[$];
  logic [127:0] acc_q[$];
  logic [15:0]  wr_addr_q[$];
  logic [31:0]  wr_data_q[$];
  int           wr_cyc_q[$];
  int           done_cnt, done_cyc, acc_during_stall, excess_ready, stall_unstable;
  bit           timed_out, aborted;
  logic [3:0]   snap_ctl;
  logic [15:0]  snap_addr;
  logic [31:0]  snap_data;

  // Reference requantization: floor((x + 2^(s-1)) / 2^s) in wide integers, then clamp.
  function automatic logic [7:0] quant(input logic signed [31:0] x, input int sh);
    longint d, t, q;
    d = longint'(1) << sh;
    t = longint'(x) + ((sh == 0) ? 0 : d / 2);
    if (t >= 0) q = t / d;
    else        q = -((-t + d - 1) / d);
    if (q > 127)  q = 127;
    if (q < -128) q = -128;
    return q[7:0];
  endfunction

  function automatic logic [31:0] expect_word(input logic [127:0] row, input int sh);
    logic [31:0] w;
    for (int i = 0; i < 4; i++) w[i*8 +: 8] = quant(row[i*32 +: 32], sh);
    return w;
  endfunction

  function automatic logic [127:0] next_row();
    logic [127:0] r;
    int v;
    if (stim_q.size() > 0) return stim_q.pop_front();
    for (int i = 0; i < 4; i++) begin
      case ($urandom_range(3))
        0:       v = int'($urandom);
        1:       v = int'($urandom_range(600)) - 300;
        2:       v = int'($urandom_range(70000)) - 35000;
        default: v = ($urandom_range(1) == 1) ? 32'sh7FFFFFFF : 32'sh80000000;
      endcase
      r[i*32 +: 32] = v;
    end
    return r;
  endfunction

  function automatic logic [127:0] lanes(input int l0, input int l1, input int l2, input int l3);
    return {l3, l2, l1, l0};
  endfunction

  task automatic run_job(input logic [15:0] b, input logic [15:0] n, input logic [4:0] sh,
                         input int vpct, input int rpct, input int stall,
                         input int restart_cyc, input int abort_after, input int budget);
    logic [127:0] cur;
    bit           finished, prev_stalled;
    logic [15:0]  pa;
    logic [31:0]  pd;
    acc_q.delete(); wr_addr_q.delete(); wr_data_q.delete(); wr_cyc_q.delete();
    done_cnt = 0; done_cyc = -1; acc_during_stall = 0; excess_ready = 0; stall_unstable = 0;
    timed_out = 0; aborted = 0; finished = 0; prev_stalled = 0; pa = '0; pd = '0;
    @(negedge clk);
    start = 1'b1; base_addr = b; row_count = n; shift = sh;
    bus.in_valid = 1'b0; bus.mem_ready = 1'b0;
    cur = next_row();
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      start = (c == restart_cyc);
      if (start) begin
        base_addr = 16'h5555; row_count = 16'd1; shift = 5'd7;
      end
      bus.in_valid  = ($urandom_range(99) < vpct);
      bus.in_data   = cur;
      bus.mem_ready = (c >= stall) && ($urandom_range(99) < rpct);
      if (abort_after >= 0 && wr_data_q.size() == abort_after) begin
        reset = 1'b0;
        #1;
        snap_ctl  = {bus.in_ready, bus.mem_we, busy, done};
        snap_addr = bus.mem_addr;
        snap_data = bus.mem_wdata;
        aborted   = 1;
        @(negedge clk);
        reset = 1'b1;
        break;
      end
      #1;
      if (bus.in_ready && acc_q.size() >= int'(n)) excess_ready++;
      if (bus.in_valid && bus.in_ready) begin
        acc_q.push_back(cur);
        if (c < stall) acc_during_stall++;
        cur = next_row();
      end
      if (prev_stalled && (bus.mem_addr !== pa || bus.mem_wdata !== pd)) stall_unstable++;
      prev_stalled = bus.mem_we && !bus.mem_ready;
      pa = bus.mem_addr;
      pd = bus.mem_wdata;
      if (bus.mem_we && bus.mem_ready) begin
        wr_addr_q.push_back(bus.mem_addr);
        wr_data_q.push_back(bus.mem_wdata);
        wr_cyc_q.push_back(c);
      end
      if (done) begin
        done_cnt++;
        done_cyc = c;
      end
      if (done_cnt > 0 && c >= done_cyc + 2) begin
        finished = 1;
        break;
      end
    end
    if (!finished && !aborted) timed_out = 1;
    @(negedge clk);
    start = 1'b0; bus.in_valid = 1'b0; bus.mem_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    n_checks++; if (bus.in_ready !== 1'b0) begin n_errors++; $display("FAIL reset_in_ready got %b want 0", bus.in_ready); end
    n_checks++; if (bus.mem_we !== 1'b0) begin n_errors++; $display("FAIL reset_mem_we got %b want 0", bus.mem_we); end
    n_checks++; if (bus.mem_addr !== 16'h0) begin n_errors++; $display("FAIL reset_mem_addr got %h want 0", bus.mem_addr); end
    n_checks++; if (bus.mem_wdata !== 32'h0) begin n_errors++; $display("FAIL reset_mem_wdata got %h want 0", bus.mem_wdata); end
    n_checks++; if ({busy, done} !== 2'b00) begin n_errors++; $display("FAIL reset_busy_done got %b want 00", {busy, done}); end
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    n_checks++; if ({bus.in_ready, bus.mem_we, busy, done} !== 4'b0) begin
      n_errors++; $display("FAIL idle_after_reset got %b want 0000", {bus.in_ready, bus.mem_we, busy, done});
    end
  endtask

  task automatic test_basic();
    repeat (3) stim_q.push_back(lanes(5, -3, 127, -128));
    run_job(16'h0100, 16'd3, 5'd0, 100, 100, 0, -1, -1, 200);
    stim_q.delete();
    n_checks++; if (timed_out !== 1'b0) begin n_errors++; $display("FAIL basic_timeout got %b want 0", timed_out); end
    n_checks++; if (wr_data_q.size() !== 3) begin n_errors++; $display("FAIL basic_count got %0d want 3", wr_data_q.size()); end
    for (int i = 0; i < wr_data_q.size(); i++) begin
      n_checks++; if (wr_addr_q[i] !== 16'h0100 + 16'(i)) begin n_errors++; $display("FAIL basic_addr[%0d] got %h want %h", i, wr_addr_q[i], 16'h0100 + 16'(i)); end
      n_checks++; if (wr_data_q[i] !== 32'h807FFD05) begin n_errors++; $display("FAIL basic_data[%0d] got %h want 807ffd05", i, wr_data_q[i]); end
    end
    if (wr_cyc_q.size() == 3) begin
      n_checks++; if (wr_cyc_q[0] !== 2) begin n_errors++; $display("FAIL basic_latency got %0d want 2", wr_cyc_q[0]); end
      n_checks++; if (done_cyc !== wr_cyc_q[2] + 1) begin n_errors++; $display("FAIL basic_done_cycle got %0d want %0d", done_cyc, wr_cyc_q[2] + 1); end
    end
    n_checks++; if (done_cnt !== 1) begin n_errors++; $display("FAIL basic_done_count got %0d want 1", done_cnt); end
    #1;
    n_checks++; if (bus.mem_addr !== 16'h0103) begin n_errors++; $display("FAIL basic_addr_hold got %h want 0103", bus.mem_addr); end
    n_checks++; if (bus.mem_wdata !== 32'h807FFD05) begin n_errors++; $display("FAIL basic_wdata_hold got %h want 807ffd05", bus.mem_wdata); end
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL basic_busy_after got %b want 0", busy); end
  endtask

  task automatic test_rounding();
    stim_q.push_back(lanes(24, -24, 40000, -40000));
    stim_q.push_back(lanes(8, 7, -8, -9));
    run_job(16'h0020, 16'd2, 5'd4, 100, 100, 0, -1, -1, 200);
    stim_q.delete();
    n_checks++; if (wr_data_q.size() !== 2) begin n_errors++; $display("FAIL round_count got %0d want 2", wr_data_q.size()); end
    else begin
      n_checks++; if (wr_data_q[0] !== 32'h807FFF02) begin n_errors++; $display("FAIL round_sat got %h want 807fff02", wr_data_q[0]); end
      n_checks++; if (wr_data_q[1] !== 32'hFF000001) begin n_errors++; $display("FAIL round_half got %h want ff000001", wr_data_q[1]); end
    end
  endtask

  task automatic test_random();
    logic [15:0] b, n;
    logic [4:0]  sh;
    for (int j = 0; j < 6; j++) begin
      b  = 16'($urandom);
      n  = 16'($urandom_range(12, 1));
      sh = 5'($urandom_range(31));
      run_job(b, n, sh, $urandom_range(100, 40), $urandom_range(100, 30), 0, -1, -1, 2000);
      n_checks++; if (timed_out !== 1'b0) begin n_errors++; $display("FAIL rand%0d_timeout got %b want 0", j, timed_out); end
      n_checks++; if (wr_data_q.size() !== int'(n)) begin n_errors++; $display("FAIL rand%0d_count got %0d want %0d", j, wr_data_q.size(), n); end
      for (int i = 0; i < wr_data_q.size() && i < acc_q.size(); i++) begin
        n_checks++; if (wr_data_q[i] !== expect_word(acc_q[i], int'(sh))) begin
          n_errors++; $display("FAIL rand%0d_data[%0d] got %h want %h (shift %0d)", j, i, wr_data_q[i], expect_word(acc_q[i], int'(sh)), sh);
        end
        n_checks++; if (wr_addr_q[i] !== b + 16'(i)) begin n_errors++; $display("FAIL rand%0d_addr[%0d] got %h want %h", j, i, wr_addr_q[i], b + 16'(i)); end
      end
      n_checks++; if (done_cnt !== 1) begin n_errors++; $display("FAIL rand%0d_done_count got %0d want 1", j, done_cnt); end
    end
  endtask

  task automatic test_backpressure();
    run_job(16'h0400, 16'd8, 5'd2, 100, 100, 10, -1, -1, 500);
    n_checks++; if (acc_during_stall !== 4) begin n_errors++; $display("FAIL bp_accept_depth got %0d want 4", acc_during_stall); end
    n_checks++; if (stall_unstable !== 0) begin n_errors++; $display("FAIL bp_stall_stable got %0d changes want 0", stall_unstable); end
    n_checks++; if (wr_data_q.size() !== 8) begin n_errors++; $display("FAIL bp_count got %0d want 8", wr_data_q.size()); end
    for (int i = 0; i < wr_data_q.size() && i < acc_q.size(); i++) begin
      n_checks++; if (wr_data_q[i] !== expect_word(acc_q[i], 2) || wr_addr_q[i] !== 16'h0400 + 16'(i)) begin
        n_errors++; $display("FAIL bp_word[%0d] got %h@%h want %h@%h", i, wr_data_q[i], wr_addr_q[i], expect_word(acc_q[i], 2), 16'h0400 + 16'(i));
      end
    end
  endtask

  task automatic test_edge();
    run_job(16'h0777, 16'd0, 5'd0, 100, 100, 0, -1, -1, 50);
    n_checks++; if (done_cyc !== 0 || done_cnt !== 1) begin n_errors++; $display("FAIL zero_rows_done got cyc %0d cnt %0d want 0 1", done_cyc, done_cnt); end
    n_checks++; if (wr_data_q.size() !== 0) begin n_errors++; $display("FAIL zero_rows_writes got %0d want 0", wr_data_q.size()); end
    n_checks++; if (excess_ready !== 0) begin n_errors++; $display("FAIL zero_rows_in_ready got %0d high cycles want 0", excess_ready); end

    run_job(16'hFFFF, 16'd2, 5'd1, 100, 100, 0, -1, -1, 200);
    n_checks++; if (wr_addr_q.size() !== 2) begin n_errors++; $display("FAIL wrap_count got %0d want 2", wr_addr_q.size()); end
    else begin
      n_checks++; if (wr_addr_q[0] !== 16'hFFFF || wr_addr_q[1] !== 16'h0000) begin
        n_errors++; $display("FAIL wrap_addr got %h,%h want ffff,0000", wr_addr_q[0], wr_addr_q[1]);
      end
    end

    run_job(16'h0200, 16'd4, 5'd0, 100, 100, 0, 2, -1, 200);
    n_checks++; if (wr_data_q.size() !== 4 || done_cnt !== 1) begin n_errors++; $display("FAIL restart_count got %0d writes %0d done want 4 1", wr_data_q.size(), done_cnt); end
    for (int i = 0; i < wr_data_q.size() && i < acc_q.size(); i++) begin
      n_checks++; if (wr_data_q[i] !== expect_word(acc_q[i], 0) || wr_addr_q[i] !== 16'h0200 + 16'(i)) begin
        n_errors++; $display("FAIL restart_word[%0d] got %h@%h want %h@%h", i, wr_data_q[i], wr_addr_q[i], expect_word(acc_q[i], 0), 16'h0200 + 16'(i));
      end
    end
  endtask

  task automatic test_reset_mid_job();
    run_job(16'h0300, 16'd5, 5'd3, 100, 100, 0, -1, 2, 200);
    n_checks++; if (aborted !== 1'b1) begin n_errors++; $display("FAIL abort_reached got %b want 1", aborted); end
    n_checks++; if (snap_ctl !== 4'b0 || snap_addr !== 16'h0 || snap_data !== 32'h0) begin
      n_errors++; $display("FAIL abort_outputs got ctl %b addr %h data %h want all 0", snap_ctl, snap_addr, snap_data);
    end
    n_checks++; if (done_cnt !== 0) begin n_errors++; $display("FAIL abort_no_done got %0d want 0", done_cnt); end
    run_job(16'h0300, 16'd5, 5'd3, 100, 100, 0, -1, -1, 300);
    n_checks++; if (wr_data_q.size() !== 5 || done_cnt !== 1) begin n_errors++; $display("FAIL rerun_count got %0d writes %0d done want 5 1", wr_data_q.size(), done_cnt); end
    for (int i = 0; i < wr_data_q.size() && i < acc_q.size(); i++) begin
      n_checks++; if (wr_data_q[i] !== expect_word(acc_q[i], 3) || wr_addr_q[i] !== 16'h0300 + 16'(i)) begin
        n_errors++; $display("FAIL rerun_word[%0d] got %h@%h want %h@%h", i, wr_data_q[i], wr_addr_q[i], expect_word(acc_q[i], 3), 16'h0300 + 16'(i));
      end
    end
  endtask

  task automatic test_excess_input();
    run_job(16'h0900, 16'd3, 5'd5, 100, 60, 0, -1, -1, 300);
    n_checks++; if (acc_q.size() !== 3) begin n_errors++; $display("FAIL excess_accepts got %0d want 3", acc_q.size()); end
    n_checks++; if (excess_ready !== 0) begin n_errors++; $display("FAIL excess_in_ready got %0d high cycles want 0", excess_ready); end
    n_checks++; if (wr_data_q.size() !== 3) begin n_errors++; $display("FAIL excess_writes got %0d want 3", wr_data_q.size()); end
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; base_addr = '0; row_count = '0; shift = '0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.mem_ready = 1'b0;
    test_reset();
    test_basic();
    test_rounding();
    test_random();
    test_backpressure();
    test_edge();
    test_reset_mid_job();
    test_excess_input();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/elementwise_writeback.md
Name: elementwise_writeback

Overview:
- Stage directly downstream of the elementwise array: consumes one row of `num` signed 32-bit lane results per handshake.
- Requantizes each lane to int8 by rounding arithmetic right shift plus saturation.
- Packs the `num` bytes into one word and buffers it in a small FIFO.
- Writes words to the activation SRAM at consecutive addresses, and pulses done after a programmed number of rows.

Parameters:
- num, 4, lanes per row; must match the elementwise array width.
- DEPTH, 4, packed-word FIFO entries; power of two, ≥2.
- AW, 16, SRAM address width.

Ports:
- clk  in  1  clock, all flops rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- start  in  1  one-cycle pulse; latches base_addr, row_count and shift; honoured only in IDLE
- base_addr  in  AW  first SRAM write address
- row_count  in  16  number of rows to accept and write
- shift  in  5  requantization right-shift amount, 0..31
- in_valid  in  1  row valid from the elementwise array
- in_ready  out  1  block accepts the row this cycle
- in  in  num×32 signed  lane values; lane i maps to byte i
- mem_we  out  1  write request
- mem_addr  out  AW  write address
- mem_wdata  out  num×8  packed int8 lanes; lane 0 in bits [7:0]
- mem_ready  in  1  SRAM accepts the write this cycle
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse when the job completes

Behaviour:
- Reset (reset=0), asynchronous: state IDLE, FIFO empty, all counters 0.
  - Outputs: in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0.
- Reset asserted mid-job aborts the job immediately. No done pulse. Buffered rows are discarded.
- States: IDLE, RUN, DONE.
  - IDLE → RUN on start when row_count≠0. Latches base_addr into the write-address counter and shift into the config register. Clears the accept and write counters.
  - IDLE → DONE on start when row_count=0.
  - RUN → DONE in the cycle after the row_count-th write is accepted.
  - DONE → IDLE unconditionally after one cycle. done=1 only in DONE.
  - start outside IDLE is ignored and has no effect on the latched config.
- Input handshake:
  - A row is accepted on in_valid & in_ready.
  - in_ready = (state==RUN) & (accepted < row_count) & (fifo_count + s1_valid < DEPTH).
  - in_ready is combinational and does not depend on in_valid.
  - Rows presented outside RUN, or beyond row_count, are never accepted.
- Requant stage: one register stage between acceptance and FIFO write (s1_valid, s1_data).
  - Per lane: t = x + (shift==0 ? 0 : 1<<(shift-1)), evaluated in 33-bit signed (no overflow).
  - Then r = t >>> shift.
  - Saturate: r>127 → 127; r<-128 → -128. Rounding is half toward +inf.
- FIFO: the word is written the cycle after acceptance. No bypass, so minimum latency from acceptance to mem_we is 2 cycles.
- Write port:
  - mem_we = (state==RUN) & fifo not empty. mem_addr and mem_wdata come from the FIFO head and the address counter.
  - On mem_we & mem_ready: pop the FIFO, increment mem_addr by 1 modulo 2^AW (wraps silently), increment the write counter.
  - mem_we, mem_addr and mem_wdata hold stable while mem_ready=0.
- Simultaneous FIFO push and pop in one cycle is legal and leaves fifo_count unchanged.
- When the FIFO is full, in_ready drops; s1_valid is counted so that no in-flight row is ever dropped.
- Outside RUN, mem_addr holds its last value and mem_wdata holds the last value driven.

Test Plan:
- Basic job: start with base_addr=0x0100, row_count=3, shift=0, lanes {5,-3,127,-128}, mem_ready=1.
  - Writes at 0x0100..0x0102 with mem_wdata=0x807FFD05.
  - done pulses exactly once, one cycle after the 3rd write.
- Rounding and saturation, shift=4:
  - Lanes {24,-24,40000,-40000} → bytes {2,-1,127,-128}, i.e. mem_wdata=0x807FFF02.
  - Lanes {8,7,-8,-9} → {1,0,0,-1}.
- Backpressure: row_count=8, in_valid=1 constantly, mem_ready=0 for 10 cycles.
  - in_ready falls after exactly DEPTH rows are accepted.
  - mem_addr and mem_wdata stay stable while stalled.
  - After mem_ready rises, all 8 words are written in order with no loss or duplication.
- Edge configs:
  - start with row_count=0 → done pulses next cycle; no mem_we; in_ready stays 0.
  - base_addr=0xFFFF, row_count=2 → writes at 0xFFFF then 0x0000.
  - A second start while busy=1 is ignored.
- Reset mid-job: assert reset=0 after 2 of 5 rows are written.
  - All outputs are 0 in the same cycle.
  - After reset release and a new start, the job runs cleanly from base_addr.
- Excess input: keep in_valid=1 after row_count rows are accepted.
  - in_ready stays 0 and exactly row_count writes occur.
